// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and widths for the evict transmit path.
package vector_cache_pkg;
  localparam int BUS_WIDTH            = 128;
  localparam int LINE_DATA_WIDTH      = 1024;
  localparam int EVICT_BEAT_NUM       = 1024 / BUS_WIDTH;
  localparam int TAG_WIDTH            = 16;
  localparam int INDEX_WIDTH          = 8;
  localparam int OFFSET_WIDTH         = 9;
  localparam int MSHR_ENTRY_NUM       = 64;
  localparam int MSHR_ENTRY_IDX_WIDTH = $clog2(MSHR_ENTRY_NUM);
  localparam int DB_ENTRY_IDX_WIDTH   = 4;
  localparam int TXNID_WIDTH          = 8;
  localparam int SIDEBAND_WIDTH       = 4;

  typedef enum logic {EV_IDLE, EV_SEND} evict_tx_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } addr_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]            tag;
    logic [INDEX_WIDTH-1:0]          index;
    logic [OFFSET_WIDTH-1:0]         offset;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } arb_out_req_t;

  typedef struct packed {
    logic [LINE_DATA_WIDTH-1:0] data;
    arb_out_req_t               evict_req_pld;
  } ram_to_evdb_pld_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0]            data;
    addr_t                           addr;
    logic                            last;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
  } evict_to_ds_pld_t;

  typedef struct packed {
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
  } evict_done_pld_t;
endpackage

// File: rtl/evict_line_fifo.sv
// Register-based line FIFO holding whole evicted lines; head is the line on the wire.
module evict_line_fifo
  import vector_cache_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  ram_to_evdb_pld_t push_pld,
  input  logic             pop,
  output ram_to_evdb_pld_t head,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ram_to_evdb_pld_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];
  assign full = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pld;
  end
endmodule

// File: rtl/evict_ds_tx.sv
// Serializes buffered evict lines into downstream beats and pulses evict-done per line.
module evict_ds_tx
  import vector_cache_pkg::*;
#(
  parameter int BUS_WIDTH       = 128,
  parameter int LINE_DATA_WIDTH = 1024,
  parameter int BEAT_NUM        = LINE_DATA_WIDTH / BUS_WIDTH,
  parameter int BUF_DEPTH       = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            evdb_vld,
  output logic                            evdb_rdy,
  input  ram_to_evdb_pld_t                evdb_pld,
  output logic                            ds_tx_vld,
  input  logic                            ds_tx_rdy,
  output evict_to_ds_pld_t                ds_tx_pld,
  output logic                            evict_done_vld,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_done_rob_id
);
  localparam int BEAT_W = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int BYTE_SH = $clog2(BUS_WIDTH / 8);

  evict_tx_state_e state_q, state_d;
  ram_to_evdb_pld_t head;
  arb_out_req_t     req;
  logic [CNT_W-1:0] count;
  logic             full, push, hs, pop;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_NUM-1:0][BUS_WIDTH-1:0] beats;
  logic             done_vld_q;
  evict_done_pld_t  done_pld_q;

  // evdb_rdy looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign evdb_rdy = !full;
  assign push     = evdb_vld && evdb_rdy;
  assign hs       = ds_tx_vld && ds_tx_rdy;
  assign pop      = hs && (beat_cnt == BEAT_W'(BEAT_NUM - 1));
  assign req      = head.evict_req_pld;
  assign beats    = head.data;

  evict_line_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_pld (evdb_pld),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= EV_IDLE;
    else     state_q <= state_d;
  end

  // SEND persists across line boundaries; only draining the last line returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EV_IDLE: if (push) state_d = EV_SEND;
      EV_SEND: if (pop && !push && count == CNT_W'(1)) state_d = EV_IDLE;
      default: state_d = EV_IDLE;
    endcase
  end

  always_comb begin
    ds_tx_vld              = (state_q == EV_SEND);
    ds_tx_pld              = '0;
    ds_tx_pld.data         = beats[beat_cnt];
    ds_tx_pld.addr.tag     = req.tag;
    ds_tx_pld.addr.index   = req.index;
    // Offset wraps inside the line window; no carry into index.
    ds_tx_pld.addr.offset  = req.offset + (OFFSET_WIDTH'(beat_cnt) << BYTE_SH);
    ds_tx_pld.last         = (beat_cnt == BEAT_W'(BEAT_NUM - 1));
    ds_tx_pld.rob_entry_id = req.rob_entry_id;
    ds_tx_pld.db_entry_id  = req.db_entry_id;
    ds_tx_pld.txnid        = req.txnid;
    ds_tx_pld.sideband     = req.sideband;
  end

  always_ff @(posedge clk) begin
    if (rst)     beat_cnt <= '0;
    else if (hs) beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_vld_q <= 1'b0;
      done_pld_q <= '0;
    end else begin
      done_vld_q <= pop;
      if (pop) done_pld_q.rob_entry_id <= req.rob_entry_id;
    end
  end

  assign evict_done_vld    = done_vld_q;
  assign evict_done_rob_id = done_pld_q.rob_entry_id;
endmodule

// File: tb/tb_evict_ds_tx.sv
// Bench for evict_ds_tx: vector tables, directed corner sequences, random traffic vs a queue model.
module tb_evict_ds_tx;
  import vector_cache_pkg::*;
  localparam int BN = EVICT_BEAT_NUM;

  logic clk = 1'b0;
  logic rst, evdb_vld, evdb_rdy, ds_tx_vld, ds_tx_rdy, evict_done_vld;
  ram_to_evdb_pld_t evdb_pld;
  evict_to_ds_pld_t ds_tx_pld;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_done_rob_id;

  evict_ds_tx #(.BUS_WIDTH(128), .LINE_DATA_WIDTH(1024), .BEAT_NUM(8), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .evdb_vld(evdb_vld), .evdb_rdy(evdb_rdy), .evdb_pld(evdb_pld),
    .ds_tx_vld(ds_tx_vld), .ds_tx_rdy(ds_tx_rdy), .ds_tx_pld(ds_tx_pld),
    .evict_done_vld(evict_done_vld), .evict_done_rob_id(evict_done_rob_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic ram_to_evdb_pld_t mk_line(input logic [5:0] rob, input logic [8:0] off,
                                               input logic [7:0] seed);
    ram_to_evdb_pld_t l;
    l = '0;
    for (int k = 0; k < BN; k++) l.data[k*BUS_WIDTH +: BUS_WIDTH] = {seed, 112'h0, 8'(k + 1)};
    l.evict_req_pld.tag          = 16'h1234;
    l.evict_req_pld.index        = 8'h5A;
    l.evict_req_pld.offset       = off;
    l.evict_req_pld.rob_entry_id = rob;
    l.evict_req_pld.db_entry_id  = 4'h3;
    l.evict_req_pld.txnid        = seed;
    l.evict_req_pld.sideband     = 4'hC;
    return l;
  endfunction

  function automatic ram_to_evdb_pld_t rand_line();
    ram_to_evdb_pld_t l;
    for (int w = 0; w < LINE_DATA_WIDTH / 32; w++) l.data[w*32 +: 32] = $urandom;
    l.evict_req_pld.tag          = TAG_WIDTH'($urandom);
    l.evict_req_pld.index        = INDEX_WIDTH'($urandom);
    l.evict_req_pld.offset       = OFFSET_WIDTH'($urandom);
    l.evict_req_pld.rob_entry_id = MSHR_ENTRY_IDX_WIDTH'($urandom);
    l.evict_req_pld.db_entry_id  = DB_ENTRY_IDX_WIDTH'($urandom);
    l.evict_req_pld.txnid        = TXNID_WIDTH'($urandom);
    l.evict_req_pld.sideband     = SIDEBAND_WIDTH'($urandom);
    return l;
  endfunction

  // Beat k of a line, straight from the slicing/offset rules.
  function automatic evict_to_ds_pld_t exp_beat(input ram_to_evdb_pld_t l, input int k);
    evict_to_ds_pld_t b;
    b = '0;
    b.data         = l.data[k*BUS_WIDTH +: BUS_WIDTH];
    b.addr.tag     = l.evict_req_pld.tag;
    b.addr.index   = l.evict_req_pld.index;
    b.addr.offset  = OFFSET_WIDTH'((int'(l.evict_req_pld.offset) + k * (BUS_WIDTH / 8)) % 512);
    b.last         = (k == BN - 1);
    b.rob_entry_id = l.evict_req_pld.rob_entry_id;
    b.db_entry_id  = l.evict_req_pld.db_entry_id;
    b.txnid        = l.evict_req_pld.txnid;
    b.sideband     = l.evict_req_pld.sideband;
    return b;
  endfunction

  // Reference model: a queue of lines plus the index of the beat on offer.
  ram_to_evdb_pld_t mq[$];
  int mk = 0;
  bit m_done = 0, m_hs, m_pop, m_push;
  logic [5:0] m_done_id = '0;
  bit chk_en = 0;
  int cyc = 0, dut_hs = 0, dut_done = 0;
  int done_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (ds_tx_vld === 1'b1 && ds_tx_rdy) dut_hs++;
    if (evict_done_vld === 1'b1) begin dut_done++; done_cyc.push_back(cyc); end
    if (chk_en) begin
      chk("sb_evdb_rdy", 256'(evdb_rdy), 256'(mq.size() < 2));
      chk("sb_ds_tx_vld", 256'(ds_tx_vld), 256'(mq.size() != 0));
      if (mq.size() != 0) chk("sb_pld", 256'(ds_tx_pld), 256'(exp_beat(mq[0], mk)));
      chk("sb_done_vld", 256'(evict_done_vld), 256'(m_done));
      chk("sb_done_id", 256'(evict_done_rob_id), 256'(m_done_id));
    end
    if (rst) begin
      mq.delete(); mk = 0; m_done = 0; m_done_id = '0;
    end else begin
      m_hs   = (mq.size() != 0) && ds_tx_rdy;
      m_pop  = m_hs && (mk == BN - 1);
      m_push = evdb_vld && (mq.size() < 2);
      m_done = m_pop;
      if (m_pop) m_done_id = mq[0].evict_req_pld.rob_entry_id;
      if (m_hs) mk = (mk + 1) % BN;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(evdb_pld);
    end
  end

  typedef struct {
    bit         rdy;
    bit         vld;
    logic [7:0] lo;
    logic [8:0] off;
    bit         last;
    bit         done;
  } vec_t;
  vec_t tbl[20];

  task automatic run_tbl(input int base, input ram_to_evdb_pld_t l);
    @(posedge clk); #1; evdb_vld = 1; evdb_pld = l; ds_tx_rdy = 1;
    @(posedge clk); #1; evdb_vld = 0;
    for (int i = 0; i < 10; i++) begin
      ds_tx_rdy = tbl[base+i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_vld", base + i), 256'(ds_tx_vld), 256'(tbl[base+i].vld));
      if (tbl[base+i].vld) begin
        chk($sformatf("tbl%0d_data", base + i), 256'(ds_tx_pld.data), 256'(tbl[base+i].lo));
        chk($sformatf("tbl%0d_off", base + i), 256'(ds_tx_pld.addr.offset), 256'(tbl[base+i].off));
        chk($sformatf("tbl%0d_last", base + i), 256'(ds_tx_pld.last), 256'(tbl[base+i].last));
        chk($sformatf("tbl%0d_tagidx", base + i), 256'({ds_tx_pld.addr.tag, ds_tx_pld.addr.index}),
            256'(24'h12345A));
      end
      chk($sformatf("tbl%0d_done", base + i), 256'(evict_done_vld), 256'(tbl[base+i].done));
      if (tbl[base+i].done)
        chk($sformatf("tbl%0d_rob", base + i), 256'(evict_done_rob_id), 256'(6'h2A));
      @(posedge clk); #1;
    end
  endtask

  task automatic push_line(input string nm, input ram_to_evdb_pld_t l);
    bit acc = 0;
    evdb_vld = 1; evdb_pld = l;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk); acc = evdb_rdy;
      @(posedge clk); #1;
    end
    if (!acc) chk({nm, "_timeout"}, 256'(acc), 256'(1));
    evdb_vld = 0;
  endtask

  task automatic wait_done(input string nm, input int base, input int n);
    for (int t = 0; t < 200 && (dut_done - base) < n; t++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_done_cnt"}, 256'(dut_done - base), 256'(n));
  endtask

  int wrap_off[8] = '{'h1F0, 'h000, 'h010, 'h020, 'h030, 'h040, 'h050, 'h060};
  int h0, d0, sz;
  bit stalled;
  evict_to_ds_pld_t prev_pld;
  ram_to_evdb_pld_t la, lb;

  initial begin
    rst = 1; evdb_vld = 0; evdb_pld = '0; ds_tx_rdy = 0;
    for (int k = 0; k < 8; k++) begin
      tbl[k]      = '{1, 1, 8'(k + 1), 9'(k * 16), k == 7, 0};
      tbl[10 + k] = '{1, 1, 8'(k + 1), 9'(wrap_off[k]), k == 7, 0};
    end
    tbl[8]  = '{1, 0, 0, 0, 0, 1};  tbl[9]  = '{1, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 0, 0, 0, 0, 1};  tbl[19] = '{1, 0, 0, 0, 0, 0};

    repeat (3) @(posedge clk); #1; rst = 0; chk_en = 1;
    @(negedge clk);
    chk("reset_evdb_rdy", 256'(evdb_rdy), 256'(1));
    chk("reset_ds_tx_vld", 256'(ds_tx_vld), 256'(0));
    chk("reset_done_vld", 256'(evict_done_vld), 256'(0));
    chk("reset_done_id", 256'(evict_done_rob_id), 256'(0));
    @(posedge clk); #1;

    run_tbl(0, mk_line(6'h2A, 9'h000, 8'h00));
    run_tbl(10, mk_line(6'h2A, 9'h1F0, 8'h00));

    // Backpressure 1,0,0,1 pattern
    h0 = dut_hs; d0 = dut_done; stalled = 0;
    push_line("bp", mk_line(6'h11, 9'h040, 8'h77));
    for (int c = 0; c < 40; c++) begin
      ds_tx_rdy = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (stalled) chk("bp_hold", 256'(ds_tx_pld), 256'(prev_pld));
      stalled = ds_tx_vld && !ds_tx_rdy; prev_pld = ds_tx_pld;
      @(posedge clk); #1;
    end
    chk("bp_hs_cnt", 256'(dut_hs - h0), 256'(8));
    chk("bp_done_cnt", 256'(dut_done - d0), 256'(1));

    // Full FIFO: third line waits for the first to drain
    h0 = dut_hs; d0 = dut_done; ds_tx_rdy = 0;
    push_line("full1", mk_line(6'h01, 9'h000, 8'hA1));
    push_line("full2", mk_line(6'h02, 9'h010, 8'hA2));
    @(negedge clk);
    chk("full_rdy_low", 256'(evdb_rdy), 256'(0));
    @(posedge clk); #1;
    fork
      push_line("full3", mk_line(6'h03, 9'h020, 8'hA3));
      begin repeat (3) @(posedge clk); #1; ds_tx_rdy = 1; end
    join
    wait_done("full", d0, 3);
    chk("full_hs_cnt", 256'(dut_hs - h0), 256'(24));
    sz = done_cyc.size();
    chk("full_gap12", 256'(done_cyc[sz-2] - done_cyc[sz-3]), 256'(8));
    chk("full_gap23", 256'(done_cyc[sz-1] - done_cyc[sz-2]), 256'(8));

    // Reset after beat 3 of A with B buffered
    ds_tx_rdy = 0; h0 = dut_hs;
    push_line("rsta", mk_line(6'h21, 9'h000, 8'hB1));
    push_line("rstb", mk_line(6'h22, 9'h000, 8'hB2));
    d0 = dut_done; ds_tx_rdy = 1;
    repeat (4) @(posedge clk); #1;
    chk("rst_hs_cnt", 256'(dut_hs - h0), 256'(4));
    ds_tx_rdy = 0; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_vld", 256'(ds_tx_vld), 256'(0));
    chk("rst_done", 256'(evict_done_vld), 256'(0));
    chk("rst_rdy", 256'(evdb_rdy), 256'(1));
    @(posedge clk); #1;
    la = mk_line(6'h23, 9'h0A0, 8'hC3);
    push_line("rstc", la);
    ds_tx_rdy = 1;
    @(negedge clk);
    chk("rstc_beat0", 256'(ds_tx_pld), 256'(exp_beat(la, 0)));
    @(posedge clk); #1;
    wait_done("rstc", d0, 1);
    chk("rstc_done_id", 256'(evict_done_rob_id), 256'(6'h23));

    // Push during the last-beat pop of a lone line
    d0 = dut_done;
    la = mk_line(6'h31, 9'h000, 8'hD1);
    lb = mk_line(6'h32, 9'h100, 8'hD2);
    push_line("lpa", la);
    repeat (7) @(posedge clk); #1;
    evdb_vld = 1; evdb_pld = lb;
    @(negedge clk);
    chk("lp_last", 256'(ds_tx_pld.last), 256'(1));
    chk("lp_rdy", 256'(evdb_rdy), 256'(1));
    @(posedge clk); #1; evdb_vld = 0;
    @(negedge clk);
    chk("lp_nobubble", 256'(ds_tx_pld), 256'(exp_beat(lb, 0)));
    chk("lp_done", 256'(evict_done_vld), 256'(1));
    chk("lp_done_id", 256'(evict_done_rob_id), 256'(6'h31));
    @(posedge clk); #1;
    @(negedge clk);
    chk("lp_done_once", 256'(evict_done_vld), 256'(0));
    @(posedge clk); #1;
    wait_done("lp", d0, 2);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      evdb_vld = ($urandom_range(0, 2) != 0);
      evdb_pld = rand_line();
      ds_tx_rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    rst = 0; evdb_vld = 0; ds_tx_rdy = 1;
    repeat (30) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
